reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Write-side counterpart of the register read/forwarding path. It merges general-register writes from the WB stage and from a long-latency unit (divider, CP0 move, or a late load) into the single regfile write port.
- Long-latency writes that collide with WB writes are held in a small in-order queue.
- Queued and in-flight writes are exposed to the ID-stage read path so readers see the newest value before it lands in the regfile.

Parameters:
- DEPTH, 2, queue entries; power of two, ≥2.
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_write_en  in  1  WB-stage write request; always accepted.
- wb_write_addr  in  ADDR_WIDTH  WB destination register.
- wb_write_data  in  DATA_WIDTH  WB write data.
- lu_write_valid  in  1  long-latency unit write request.
- lu_write_ready  out  1  arbiter can accept an lu write this cycle.
- lu_write_addr  in  ADDR_WIDTH  lu destination register.
- lu_write_data  in  DATA_WIDTH  lu write data.
- reg_write_en  out  1  regfile write enable (registered).
- reg_write_addr  out  ADDR_WIDTH  regfile write address (registered).
- reg_write_data  out  DATA_WIDTH  regfile write data (registered).
- query_addr_1, query_addr_2  in  ADDR_WIDTH  ID-stage read addresses.
- pending_hit_1, pending_hit_2  out  1  newer value pending for that address.
- pending_data_1, pending_data_2  out  DATA_WIDTH  that pending value; 0 when no hit.
- pending_count  out  log2(DEPTH)+1  valid queue entries.

Behaviour:
- Reset (async, rst=0):
  - queue emptied; all entries invalid.
  - reg_write_en=0, reg_write_addr=0, reg_write_data=0, pending_count=0.
  - lu_write_ready=1 once rst deasserts.
- Handshake:
  - lu_write_ready = (pending_count != DEPTH); combinational from registered state only.
  - An lu transfer occurs when lu_write_valid && lu_write_ready.
  - lu_write_valid may stay high across not-ready cycles; its payload must stay stable until the transfer.
- Per-cycle output select, in priority order:
  1. wb_write_en → output WB write.
  2. Else queue non-empty → pop head and output it.
  3. Else lu transfer → output lu write directly (bypass, no enqueue).
  4. Else reg_write_en=0 next cycle.
- Latency: any accepted write appears on reg_write_* exactly 1 cycle after acceptance or pop.
- Enqueue: an lu transfer not taken by rule 3 is pushed at the tail. The same cycle may pop (rule 2) and push; pending_count is then unchanged.
- r0 rule: writes to address 0 from either source are accepted but discarded. They are never enqueued, never output, and never hit. wb to r0 does not block the queue pop.
- Stale-write kill: when wb_write_en with addr≠0, every valid queue entry with the same address is invalidated in that cycle.
  - Invalid entries are popped without asserting reg_write_en. Such a pop consumes no output slot, so the next valid entry may be popped in the same cycle.
  - pending_count counts valid entries only.
- Same-address lu writes: kept in order; the regfile ends with the newest.
- Query, combinational, per port:
  - Only addresses ≠0 can hit.
  - Hit if a valid queue entry matches (newest entry wins); otherwise hit if reg_write_en && reg_write_addr matches.
  - Queue entries have priority over the output register.
- Wrap-around: head/tail pointers wrap modulo DEPTH; full and empty are distinguished by pending_count.
- Reset mid-operation drops all queued writes with no regfile write.

Optional Feature:
- Macro: REG_WRITE_ARB_STAT_EN.
- Defined:
  - Extra output ports stat_conflict_count (32-bit) and stat_kill_count (32-bit), both reset to 0.
  - stat_conflict_count increments each cycle lu_write_valid && !lu_write_ready.
  - stat_kill_count increments by the number of entries invalidated per cycle.
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- WB only: wb write r3=0x11 at cycle t → reg_write_en=1, addr=3, data=0x11 at t+1; lu_write_ready stays 1.
- lu bypass: queue empty, WB idle, lu write r5=0xAA → output r5=0xAA next cycle; pending_count stays 0.
- Collision and drain:
  - Stimulus: wb r1=0x1 together with lu r2=0x2, then wb r4=0x4 together with lu r6=0x6, then idle.
  - Response: outputs r1, r4, r2, r6 on successive cycles.
  - lu_write_ready=0 while pending_count=2; ready returns once a drain frees an entry.
- Stale kill:
  - Stimulus: queue holds r7=0x70; wb writes r7=0x77.
  - Response: entry invalidated, r7 never written with 0x70, query r7 returns data 0x77 via the output register on the following cycle.
- r0 and query priority:
  - lu r0=0xFF accepted and discarded, pending_hit=0 for query 0.
  - Queue holds r9=0x90 while output reg holds r9=0x99 → pending_data=0x90.
- Reset mid-drain: rst low with 2 queued entries → reg_write_en=0 immediately, pending_count=0, and no queued write ever reaches the regfile.

Source files
------------

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Brief    : Merges WB-stage and long-latency register writes into the single
//            regfile write port. Colliding long-latency writes wait in an
//            in-order queue that the ID-stage read path can query.
//            Optional macro REG_WRITE_ARB_STAT_EN adds conflict/kill counters.
// Revision : 1.0  initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_write_en,
    input  logic [ADDR_WIDTH-1:0]   wb_write_addr,
    input  logic [DATA_WIDTH-1:0]   wb_write_data,
    input  logic                    lu_write_valid,
    output logic                    lu_write_ready,
    input  logic [ADDR_WIDTH-1:0]   lu_write_addr,
    input  logic [DATA_WIDTH-1:0]   lu_write_data,
    output logic                    reg_write_en,
    output logic [ADDR_WIDTH-1:0]   reg_write_addr,
    output logic [DATA_WIDTH-1:0]   reg_write_data,
    input  logic [ADDR_WIDTH-1:0]   query_addr_1,
    input  logic [ADDR_WIDTH-1:0]   query_addr_2,
    output logic                    pending_hit_1,
    output logic                    pending_hit_2,
    output logic [DATA_WIDTH-1:0]   pending_data_1,
    output logic [DATA_WIDTH-1:0]   pending_data_2,
    output logic [$clog2(DEPTH):0]  pending_count
`ifdef REG_WRITE_ARB_STAT_EN
    ,
    output logic [31:0]             stat_conflict_count,
    output logic [31:0]             stat_kill_count
`endif
);

    localparam int                  c_cnt_w     = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0]  c_depth_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_one       = c_cnt_w'(1);

    // Queue is kept compacted: slot 0 is the head, slots [0, r_count) are valid.
    logic [ADDR_WIDTH-1:0] r_q_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_q_data [DEPTH];
    logic [c_cnt_w-1:0]    r_count;
    logic                  r_out_en;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic                  w_wb_eff;
    logic                  w_lu_xfer;
    logic                  w_lu_live;
    logic                  w_pop;
    logic                  w_bypass;
    logic                  w_push;
    logic [c_cnt_w-1:0]    w_sv_cnt;
    logic [c_cnt_w-1:0]    w_base;
    logic [c_cnt_w-1:0]    w_n_count;
    logic [ADDR_WIDTH-1:0] w_sv_addr [DEPTH];
    logic [DATA_WIDTH-1:0] w_sv_data [DEPTH];
    logic [ADDR_WIDTH-1:0] w_n_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] w_n_data  [DEPTH];
`ifdef REG_WRITE_ARB_STAT_EN
    logic [c_cnt_w-1:0]    w_kill_cnt;
`endif

    assign lu_write_ready = (r_count != c_depth_cnt);
    assign w_lu_xfer      = lu_write_valid && lu_write_ready;
    assign w_lu_live      = w_lu_xfer && (lu_write_addr != '0);
    assign w_wb_eff       = wb_write_en && (wb_write_addr != '0);

    // Drop entries superseded by the WB write, closing the gaps so that an
    // invalidated entry never costs an output slot or queue space.
    always_comb begin : p_compact
        w_sv_cnt = '0;
`ifdef REG_WRITE_ARB_STAT_EN
        w_kill_cnt = '0;
`endif
        for (int j = 0; j < DEPTH; j++) begin
            w_sv_addr[j] = '0;
            w_sv_data[j] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (c_cnt_w'(i) < r_count) begin
                if (w_wb_eff && (r_q_addr[i] == wb_write_addr)) begin
`ifdef REG_WRITE_ARB_STAT_EN
                    w_kill_cnt = w_kill_cnt + c_one;
`endif
                end else begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (c_cnt_w'(j) == w_sv_cnt) begin
                            w_sv_addr[j] = r_q_addr[i];
                            w_sv_data[j] = r_q_data[i];
                        end
                    end
                    w_sv_cnt = w_sv_cnt + c_one;
                end
            end
        end
    end

    assign w_pop     = !w_wb_eff && (w_sv_cnt != '0);
    assign w_bypass  = !w_wb_eff && (w_sv_cnt == '0) && w_lu_live;
    assign w_push    = w_lu_live && !w_bypass;
    assign w_base    = w_pop ? (w_sv_cnt - c_one) : w_sv_cnt;
    assign w_n_count = w_push ? (w_base + c_one) : w_base;

    always_comb begin : p_next_q
        for (int j = 0; j < DEPTH; j++) begin
            if (w_pop) begin
                w_n_addr[j] = (j < DEPTH - 1) ? w_sv_addr[(j + 1) % DEPTH] : '0;
                w_n_data[j] = (j < DEPTH - 1) ? w_sv_data[(j + 1) % DEPTH] : '0;
            end else begin
                w_n_addr[j] = w_sv_addr[j];
                w_n_data[j] = w_sv_data[j];
            end
            if (w_push && (c_cnt_w'(j) == w_base)) begin
                w_n_addr[j] = lu_write_addr;
                w_n_data[j] = lu_write_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= '0;
            r_out_en   <= 1'b0;
            r_out_addr <= '0;
            r_out_data <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                r_q_addr[j] <= '0;
                r_q_data[j] <= '0;
            end
        end else begin
            r_count  <= w_n_count;
            r_out_en <= w_wb_eff || w_pop || w_bypass;
            for (int j = 0; j < DEPTH; j++) begin
                r_q_addr[j] <= w_n_addr[j];
                r_q_data[j] <= w_n_data[j];
            end
            if (w_wb_eff) begin
                r_out_addr <= wb_write_addr;
                r_out_data <= wb_write_data;
            end else if (w_pop) begin
                r_out_addr <= w_sv_addr[0];
                r_out_data <= w_sv_data[0];
            end else if (w_bypass) begin
                r_out_addr <= lu_write_addr;
                r_out_data <= lu_write_data;
            end
        end
    end

    // Later queue slots are newer, so the last match wins over earlier ones
    // and over the output register.
    function automatic logic [DATA_WIDTH:0] f_lookup(input logic [ADDR_WIDTH-1:0] qa);
        logic [DATA_WIDTH:0] res;
        res = '0;
        if (qa != '0) begin
            if (r_out_en && (r_out_addr == qa)) res = {1'b1, r_out_data};
            for (int i = 0; i < DEPTH; i++) begin
                if ((c_cnt_w'(i) < r_count) && (r_q_addr[i] == qa)) res = {1'b1, r_q_data[i]};
            end
        end
        return res;
    endfunction

    assign {pending_hit_1, pending_data_1} = f_lookup(query_addr_1);
    assign {pending_hit_2, pending_data_2} = f_lookup(query_addr_2);

    assign reg_write_en   = r_out_en;
    assign reg_write_addr = r_out_addr;
    assign reg_write_data = r_out_data;
    assign pending_count  = r_count;

`ifdef REG_WRITE_ARB_STAT_EN
    logic [31:0] r_stat_conflict;
    logic [31:0] r_stat_kill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_conflict <= '0;
            r_stat_kill     <= '0;
        end else begin
            if (lu_write_valid && !lu_write_ready) r_stat_conflict <= r_stat_conflict + 32'd1;
            r_stat_kill <= r_stat_kill + 32'(w_kill_cnt);
        end
    end

    assign stat_conflict_count = r_stat_conflict;
    assign stat_kill_count     = r_stat_kill;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Brief    : Scoreboard bench for reg_write_arbiter with a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_write_en = 1'b0;
    logic [4:0]  wb_write_addr = '0;
    logic [31:0] wb_write_data = '0;
    logic        lu_write_valid = 1'b0;
    logic        lu_write_ready;
    logic [4:0]  lu_write_addr = '0;
    logic [31:0] lu_write_data = '0;
    logic        reg_write_en;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic [4:0]  query_addr_1 = '0;
    logic [4:0]  query_addr_2 = '0;
    logic        pending_hit_1, pending_hit_2;
    logic [31:0] pending_data_1, pending_data_2;
    logic [1:0]  pending_count;
`ifdef REG_WRITE_ARB_STAT_EN
    logic [31:0] stat_conflict_count, stat_kill_count;
`endif

    reg_write_arbiter #(.DEPTH(DEPTH), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .wb_write_en(wb_write_en), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
        .lu_write_valid(lu_write_valid), .lu_write_ready(lu_write_ready),
        .lu_write_addr(lu_write_addr), .lu_write_data(lu_write_data),
        .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
        .query_addr_1(query_addr_1), .query_addr_2(query_addr_2),
        .pending_hit_1(pending_hit_1), .pending_hit_2(pending_hit_2),
        .pending_data_1(pending_data_1), .pending_data_2(pending_data_2),
        .pending_count(pending_count)
`ifdef REG_WRITE_ARB_STAT_EN
        , .stat_conflict_count(stat_conflict_count), .stat_kill_count(stat_kill_count)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;
    ent_t mq[$];   // model: pending writes, oldest first
    ent_t sb[$];   // expected regfile writes, in order
    logic mo_en = 1'b0;
    ent_t mo    = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] m_lookup(input logic [4:0] qa);
        if (qa == 5'd0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == qa) return {1'b1, mq[i].d};
        if (mo_en && mo.a == qa) return {1'b1, mo.d};
        return '0;
    endfunction

    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic [4:0] q1, input logic [4:0] q2, output logic xfer);
        logic ready_e;
        logic n_en;
        ent_t n;
        @(negedge clk);
        wb_write_en = we; wb_write_addr = wa; wb_write_data = wd;
        lu_write_valid = lv; lu_write_addr = la; lu_write_data = ld;
        query_addr_1 = q1; query_addr_2 = q2;
        #1;
        ready_e = (mq.size() != DEPTH);
        chk("ready", lu_write_ready, ready_e);
        chk("count", pending_count, mq.size());
        chk("wr_en", reg_write_en, mo_en);
        chk("query1", {pending_hit_1, pending_data_1}, m_lookup(q1));
        chk("query2", {pending_hit_2, pending_data_2}, m_lookup(q2));
        xfer = lv && ready_e;
        n_en = 1'b0;
        n    = mo;
        if (we && wa != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--)
                if (mq[i].a == wa) mq.delete(i);
            n_en = 1'b1; n = '{a: wa, d: wd};
            if (xfer && la != 5'd0) mq.push_back('{a: la, d: ld});
        end else if (mq.size() > 0) begin
            n_en = 1'b1; n = mq.pop_front();
            if (xfer && la != 5'd0) mq.push_back('{a: la, d: ld});
        end else if (xfer && la != 5'd0) begin
            n_en = 1'b1; n = '{a: la, d: ld};
        end
        mo_en = n_en;
        mo    = n;
        if (n_en) sb.push_back(n);
    endtask

    task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
        logic x;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q1, q2, x);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        chk("pre_reset_count", pending_count, mq.size());
        rst = 1'b0;
        wb_write_en = 1'b0; lu_write_valid = 1'b0;
        #1;
        chk("rst_wr_en", reg_write_en, 1'b0);
        chk("rst_count", pending_count, 2'd0);
        mq.delete();
        mo_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: every regfile write must match the next expected write.
    initial begin : p_monitor
        ent_t e;
        while (!done) begin
            @(posedge clk); #2;
            if (rst && reg_write_en) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write actual=r%0d:%0h expected=none", reg_write_addr, reg_write_data);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", reg_write_addr, e.a);
                    chk("wr_data", reg_write_data, e.d);
                end
            end
        end
    end

    initial begin : p_timeout
        #1000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : p_stim
        logic        x;
        logic        rlv;
        logic [4:0]  rla;
        logic [31:0] rld;
        #7;
        chk("reset_wr_en", reg_write_en, 1'b0);
        chk("reset_wr_addr", reg_write_addr, 5'd0);
        chk("reset_wr_data", reg_write_data, 32'd0);
        chk("reset_count", pending_count, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_after_reset", lu_write_ready, 1'b1);

        step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, x);
        idle(5'd3, 5'd5);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hAA, 5'd5, 5'd3, x);
        idle(5'd5, 5'd0);
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 5'd1, 5'd2, x);
        step(1'b1, 5'd4, 32'h4, 1'b1, 5'd6, 32'h6, 5'd2, 5'd4, x);
        repeat (4) idle(5'd2, 5'd6);
        step(1'b1, 5'd8, 32'h8, 1'b1, 5'd7, 32'h70, 5'd7, 5'd8, x);
        step(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 5'd7, 5'd8, x);
        idle(5'd7, 5'd0);
        idle(5'd7, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF, 5'd0, 5'd0, x);
        idle(5'd0, 5'd9);
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h90, 5'd9, 5'd0, x);
        idle(5'd9, 5'd9);
        idle(5'd9, 5'd0);
        step(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h202, 5'd2, 5'd0, x);
        step(1'b1, 5'd4, 32'h404, 1'b1, 5'd6, 32'h606, 5'd6, 5'd2, x);
        do_reset();
        repeat (3) idle(5'd2, 5'd6);

        rlv = 1'b0; rla = '0; rld = '0;
        for (int c = 0; c < 3000; c++) begin
            logic we;
            we = ($urandom_range(0, 9) < 4);
            step(we, 5'($urandom_range(0, 7)), $urandom, rlv, rla, rld,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), x);
            if (!(rlv && !x)) begin
                rlv = ($urandom_range(0, 9) < 6);
                rla = 5'($urandom_range(0, 7));
                rld = $urandom;
            end
        end
        repeat (6) idle(5'd0, 5'd0);
        @(posedge clk); #3;
        done = 1'b1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
